scan_scheduler: RTL and testbench
=================================

# scan_scheduler

Sequencing controller for the Viola-Jones detection datapath. On a start pulse it waits a fixed number of cycles for the integral-image pyramid to settle. It then walks every legal 24x24 window position of every pyramid level, issuing window coordinates to `vj_pipeline` under a valid/ready handshake, and drains the pipeline. Face detections returned by the pipeline are buffered in a small FIFO for the UART/host side. It replaces the free-running index counters in `top`.

## Interface
Parameters:
- `LEVELS`, 13: number of pyramid levels scanned, indices 0..LEVELS-1.
- `WINDOW_SIZE`, 24: window edge in pixels.
- `INT_WAIT`, 76800: cycles between start and first window issue.
- `PIPE_LATENCY`, 2914: cycles from the last window accept until its result is guaranteed out.
- `FIFO_DEPTH`, 8: detection FIFO entries; must be a power of 2, minimum 2.

Ports:
- `clock`, in, 1: single clock; all state on posedge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `start`, in, 1: one-cycle pulse; honoured only in IDLE.
- `level_idx`, out, 4: level whose dimensions are being looked up; equals `win_level`.
- `level_width`, in, 32: combinational width of level `level_idx`.
- `level_height`, in, 32: combinational height of level `level_idx`.
- `win_valid`, out, 1: window coordinates valid.
- `win_ready`, in, 1: pipeline accepts the window.
- `win_level`, out, 4: current level.
- `win_row`, out, 32: current row index.
- `win_col`, out, 32: current column index.
- `face_in_valid`, in, 1: pipeline reports a detection.
- `face_in_level`, in, 4: level of the detection.
- `face_in_row`, in, 32: row of the detection.
- `face_in_col`, in, 32: column of the detection.
- `face_out_valid`, out, 1: FIFO non-empty.
- `face_out_ready`, in, 1: consumer pops.
- `face_out_level`, out, 4: FIFO head level.
- `face_out_row`, out, 32: FIFO head row.
- `face_out_col`, out, 32: FIFO head column.
- `busy`, out, 1: state is not IDLE.
- `done`, out, 1: one-cycle pulse at the end of a scan.
- `face_count`, out, 16: detections accepted since the last start; saturates at 16'hFFFF.
- `overflow`, out, 1: sticky; a detection was dropped.

## Operation
- State machine states: IDLE, WAIT_INT, SCAN, DRAIN, DONE.
- IDLE:
  - On `start`: go to WAIT_INT.
  - Load the wait counter with INT_WAIT-1.
  - Clear `face_count`, `overflow`, level, row and column.
  - FIFO contents are kept.
- WAIT_INT: decrement the wait counter; at 0, go to SCAN.
- SCAN: a level is legal when `level_width >= WINDOW_SIZE` and `level_height >= WINDOW_SIZE`.
  - Legal level: `win_valid` = 1.
    - Coordinates advance only on `win_valid & win_ready`.
    - Column advances first: col+1 until col == width-WINDOW_SIZE.
    - Then the column returns to 0 and the row increments, until row == height-WINDOW_SIZE.
    - Then the level increments and row and column return to 0.
  - Illegal level: `win_valid` = 0 for exactly one cycle, then the level increments.
  - After the last window of level LEVELS-1 is accepted, or level LEVELS-1 is skipped, go to DRAIN.
  - Load the drain counter with PIPE_LATENCY-1.
- DRAIN:
  - `win_valid` = 0.
  - Decrement the drain counter; at 0, go to DONE.
- DONE:
  - `done` = 1 for one cycle, then IDLE.
  - Level, row and column return to 0.
- `start` outside IDLE is ignored.
- Detection FIFO:
  - Pushes occur in any state.
  - Push when `face_in_valid` and (not full, or pop in the same cycle).
  - If `face_in_valid` arrives while full with no pop, the entry is dropped and `overflow` is set.
  - Each accepted push increments `face_count`.
  - Pop on `face_out_valid & face_out_ready`.
  - Push and pop in the same cycle leave occupancy unchanged; the FIFO order is preserved.
  - Pointers are log2(FIFO_DEPTH) bits and wrap; one extra bit distinguishes full from empty.
- Width rules: the `level_width - WINDOW_SIZE` comparisons are unsigned 32-bit and are evaluated only after the legality check, so no underflow can occur.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0: `win_valid`, `win_level`, `win_row`, `win_col`, `face_out_*`, `busy`, `done`, `face_count`, `overflow`.
  - FIFO empty.
- Reset mid-scan aborts immediately and no `done` is produced.
- Start latency: `start` sampled at edge 0 puts the block in WAIT_INT. The first `win_valid` is visible after edge INT_WAIT+1.
- With `win_ready` held at 1, one window issues per cycle.
- The window outputs are registered and hold stable while `win_valid & !win_ready`.
- Scan length for legal level L is (W-23)*(H-23) windows with `win_ready` held at 1, for WINDOW_SIZE = 24.
- After the last accept, `done` rises PIPE_LATENCY+1 cycles later.
- `busy` is high from the cycle after `start` through the DONE cycle inclusive.
- FIFO:
  - `face_out_*` are registered from the head entry.
  - A push into an empty FIFO is visible on the next cycle.

## Test plan
- Stimulus: LEVELS=2, INT_WAIT=4, PIPE_LATENCY=5; level0 26x25, level1 20x30; `win_ready`=1; start. Required response:
  - Six windows (0,0,0), (0,0,1), (0,0,2), (0,1,0), (0,1,1), (0,1,2).
  - Level1 skipped with one idle cycle.
  - `done` 6 cycles after the last accept.
- Stimulus: same configuration, `win_ready` toggling 1/0. Required response: coordinates hold during stalls, the same six windows appear in order with none duplicated, and the total scan spans 12 cycles.
- Stimulus: 9 detections in consecutive cycles with FIFO_DEPTH=8 and no pops. Required response: `face_count`=8, `overflow`=1, and pops return the first 8 entries in order.
- Stimulus: FIFO full with simultaneous push and pop. Required response: the push is accepted, `overflow` stays 0, and occupancy stays 8.
- Stimulus: `start` pulsed during SCAN, then reset asserted mid-SCAN. Required response: the second `start` is ignored; on reset all outputs go to 0 asynchronously, `busy`=0, and no `done`.
- Stimulus: new `start` after a completed scan with stale FIFO entries. Required response: `face_count` and `overflow` clear, and the FIFO entries remain poppable.

Source files
------------

// File: rtl/scan_scheduler.sv
// Scan scheduler: waits for the integral pyramid, walks every 24x24 window of every level, drains the pipeline, buffers detections.
// Latency: first window INT_WAIT+1 cycles after start; done PIPE_LATENCY+1 cycles after the last accept (with the final level skipped).
// Backpressure: window coordinates hold while win_valid & !win_ready; detections arriving into a full FIFO without a pop are dropped and flagged.
module scan_scheduler #(
  parameter int LEVELS       = 13,
  parameter int WINDOW_SIZE  = 24,
  parameter int INT_WAIT     = 76800,
  parameter int PIPE_LATENCY = 2914,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [3:0]  level_idx,
  input  logic [31:0] level_width,
  input  logic [31:0] level_height,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [3:0]  win_level,
  output logic [31:0] win_row,
  output logic [31:0] win_col,
  input  logic        face_in_valid,
  input  logic [3:0]  face_in_level,
  input  logic [31:0] face_in_row,
  input  logic [31:0] face_in_col,
  output logic        face_out_valid,
  input  logic        face_out_ready,
  output logic [3:0]  face_out_level,
  output logic [31:0] face_out_row,
  output logic [31:0] face_out_col,
  output logic        busy,
  output logic        done,
  output logic [15:0] face_count,
  output logic        overflow
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_INT, S_SCAN, S_DRAIN, S_DONE} state_t;

  localparam logic [31:0] WS         = 32'(WINDOW_SIZE);
  localparam logic [3:0]  LAST_LVL   = 4'(LEVELS - 1);
  localparam logic [31:0] WAIT_LOAD  = 32'(INT_WAIT - 1);
  localparam logic [31:0] DRAIN_LOAD = 32'(PIPE_LATENCY - 1);
  localparam int          AW         = $clog2(FIFO_DEPTH);

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [3:0]  r_level;
  logic [31:0] r_row;
  logic [31:0] r_col;
  logic        r_win_valid;
  logic        r_busy;
  logic        r_done;

  // The subtractions are only consulted while the level is known legal, so they never wrap.
  logic w_legal;
  logic w_col_last;
  logic w_row_last;
  assign w_legal    = (level_width >= WS) && (level_height >= WS);
  assign w_col_last = (r_col == (level_width - WS));
  assign w_row_last = (r_row == (level_height - WS));

  assign level_idx = r_level;
  assign win_level = r_level;
  assign win_row   = r_row;
  assign win_col   = r_col;
  assign win_valid = r_win_valid;
  assign busy      = r_busy;
  assign done      = r_done;

  // Sequencer: each new level spends one cycle with win_valid low while its dimensions are looked up.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_level     <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_win_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_WAIT_INT;
            r_cnt   <= WAIT_LOAD;
            r_level <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT_INT: begin
          if (r_cnt == '0) r_state <= S_SCAN;
          else             r_cnt   <= r_cnt - 32'd1;
        end
        S_SCAN: begin
          if (!r_win_valid) begin
            if (w_legal) begin
              r_win_valid <= 1'b1;
            end else if (r_level == LAST_LVL) begin
              r_state <= S_DRAIN;
              r_cnt   <= DRAIN_LOAD;
            end else begin
              r_level <= r_level + 4'd1;
            end
          end else if (win_ready) begin
            if (!w_col_last) begin
              r_col <= r_col + 32'd1;
            end else begin
              r_col <= '0;
              if (!w_row_last) begin
                r_row <= r_row + 32'd1;
              end else begin
                r_row       <= '0;
                r_win_valid <= 1'b0;
                if (r_level == LAST_LVL) begin
                  r_state <= S_DRAIN;
                  r_cnt   <= DRAIN_LOAD;
                end else begin
                  r_level <= r_level + 4'd1;
                end
              end
            end
          end
        end
        S_DRAIN: begin
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_win_valid <= 1'b0;
          r_level     <= '0;
          r_row       <= '0;
          r_col       <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Detection FIFO: pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] w_rd_next;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic        w_empty_after_pop;
  logic        w_nonempty_next;
  logic        w_clear;
  logic [3:0]  r_mem_level [FIFO_DEPTH];
  logic [31:0] r_mem_row   [FIFO_DEPTH];
  logic [31:0] r_mem_col   [FIFO_DEPTH];
  logic        r_out_valid;
  logic [3:0]  r_out_level;
  logic [31:0] r_out_row;
  logic [31:0] r_out_col;

  assign w_full            = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop             = r_out_valid & face_out_ready;
  assign w_push            = face_in_valid & (~w_full | w_pop);
  assign w_drop            = face_in_valid & w_full & ~w_pop;
  assign w_rd_next         = r_rd_ptr + {{AW{1'b0}}, w_pop};
  assign w_empty_after_pop = (r_wr_ptr == w_rd_next);
  assign w_nonempty_next   = ~w_empty_after_pop | w_push;
  assign w_clear           = (r_state == S_IDLE) && start;

  assign face_out_valid = r_out_valid;
  assign face_out_level = r_out_level;
  assign face_out_row   = r_out_row;
  assign face_out_col   = r_out_col;

  // Storage array; written only on accepted pushes.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_level[r_wr_ptr[AW-1:0]] <= face_in_level;
      r_mem_row[r_wr_ptr[AW-1:0]]   <= face_in_row;
      r_mem_col[r_wr_ptr[AW-1:0]]   <= face_in_col;
    end
  end

  // Pointer update; simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      r_rd_ptr <= w_rd_next;
    end
  end

  // Head register: when the FIFO would otherwise be empty, the incoming entry becomes the head directly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_level <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
    end else begin
      r_out_valid <= w_nonempty_next;
      if (w_empty_after_pop && w_push) begin
        r_out_level <= face_in_level;
        r_out_row   <= face_in_row;
        r_out_col   <= face_in_col;
      end else if (!w_empty_after_pop) begin
        r_out_level <= r_mem_level[w_rd_next[AW-1:0]];
        r_out_row   <= r_mem_row[w_rd_next[AW-1:0]];
        r_out_col   <= r_mem_col[w_rd_next[AW-1:0]];
      end
    end
  end

  // Detection statistics, cleared by an honoured start; a push in that same cycle still counts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      face_count <= '0;
      overflow   <= 1'b0;
    end else if (w_clear) begin
      face_count <= w_push ? 16'd1 : 16'd0;
      overflow   <= w_drop;
    end else begin
      if (w_push && (face_count != 16'hFFFF)) face_count <= face_count + 16'd1;
      if (w_drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scan_scheduler.sv
// Directed bench for scan_scheduler: LEVELS=2, INT_WAIT=4, PIPE_LATENCY=5, FIFO_DEPTH=8.
// Level 0 is 26x25 (six windows), level 1 is 20x30 (skipped).
// Outputs are sampled at the falling edge; inputs change there too.
module tb_scan_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  level_idx;
  logic [31:0] level_width;
  logic [31:0] level_height;
  logic        win_valid;
  logic        win_ready;
  logic [3:0]  win_level;
  logic [31:0] win_row;
  logic [31:0] win_col;
  logic        face_in_valid;
  logic [3:0]  face_in_level;
  logic [31:0] face_in_row;
  logic [31:0] face_in_col;
  logic        face_out_valid;
  logic        face_out_ready;
  logic [3:0]  face_out_level;
  logic [31:0] face_out_row;
  logic [31:0] face_out_col;
  logic        busy;
  logic        done;
  logic [15:0] face_count;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  int exp_row [6] = '{0, 0, 0, 1, 1, 1};
  int exp_col [6] = '{0, 1, 2, 0, 1, 2};

  assign level_width  = (level_idx == 4'd0) ? 32'd26 : 32'd20;
  assign level_height = (level_idx == 4'd0) ? 32'd25 : 32'd30;

  scan_scheduler #(
    .LEVELS(2), .WINDOW_SIZE(24), .INT_WAIT(4), .PIPE_LATENCY(5), .FIFO_DEPTH(8)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .level_idx(level_idx), .level_width(level_width), .level_height(level_height),
    .win_valid(win_valid), .win_ready(win_ready), .win_level(win_level),
    .win_row(win_row), .win_col(win_col),
    .face_in_valid(face_in_valid), .face_in_level(face_in_level),
    .face_in_row(face_in_row), .face_in_col(face_in_col),
    .face_out_valid(face_out_valid), .face_out_ready(face_out_ready),
    .face_out_level(face_out_level), .face_out_row(face_out_row), .face_out_col(face_out_col),
    .busy(busy), .done(done), .face_count(face_count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    win_ready = 1'b0;
    face_in_valid = 1'b0;
    face_in_level = '0;
    face_in_row = '0;
    face_in_col = '0;
    face_out_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Returns at the falling edge after the edge that sampled start.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic set_det(input int id);
    face_in_level = 4'(id);
    face_in_row   = 32'(100 + id);
    face_in_col   = 32'(200 + id);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({win_valid, busy, done, overflow, face_out_valid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 00000", {win_valid, busy, done, overflow, face_out_valid});
    end
    checks++;
    if ({win_level, win_row, win_col} !== 68'h0) begin
      failures++;
      $display("FAIL reset_window: got lvl=%0d row=%0d col=%0d expected all 0", win_level, win_row, win_col);
    end
    checks++;
    if ({face_out_level, face_out_row, face_out_col, face_count} !== 84'h0) begin
      failures++;
      $display("FAIL reset_fifo: got lvl=%0d row=%0d col=%0d cnt=%0d expected all 0",
               face_out_level, face_out_row, face_out_col, face_count);
    end
  endtask

  task automatic test_scan_full_ready();
    int n = 0, first_k = 0, done_k = 0, ndone = 0;
    do_reset();
    win_ready = 1'b1;
    pulse_start();
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clock);
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL scan_busy_after_start: got %b expected 1", busy); end
      end
      if (win_valid === 1'b1) begin
        if (first_k == 0) first_k = k;
        if (n < 6) begin
          checks++;
          if (win_level !== 4'd0 || win_row !== 32'(exp_row[n]) || win_col !== 32'(exp_col[n])) begin
            failures++;
            $display("FAIL scan_window%0d: got (%0d,%0d,%0d) expected (0,%0d,%0d)",
                     n, win_level, win_row, win_col, exp_row[n], exp_col[n]);
          end
        end
        n++;
      end
      if (k == 12) begin
        checks++;
        if (win_valid !== 1'b0 || win_level !== 4'd1) begin
          failures++;
          $display("FAIL scan_skip_cycle: got valid=%b lvl=%0d expected valid=0 lvl=1", win_valid, win_level);
        end
      end
      if (done === 1'b1) begin
        if (done_k == 0) done_k = k;
        ndone++;
      end
      if (k == 18) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL scan_busy_in_done: got %b expected 1", busy); end
      end
      if (k == 19) begin
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL scan_busy_after_done: got %b expected 0", busy); end
      end
    end
    checks++;
    if (first_k != 6) begin failures++; $display("FAIL scan_first_valid: got cycle %0d expected 6", first_k); end
    checks++;
    if (n != 6) begin failures++; $display("FAIL scan_window_count: got %0d expected 6", n); end
    checks++;
    if (done_k != 18 || ndone != 1) begin
      failures++;
      $display("FAIL scan_done: got cycle %0d pulses %0d expected cycle 18 pulses 1", done_k, ndone);
    end
    win_ready = 1'b0;
  endtask

  task automatic test_scan_stall();
    int n = 0, first_k = 0, valid_cnt = 0, last_acc = 0, done_k = 0;
    logic prev_stall = 1'b0;
    logic [67:0] prev_win = '0;
    do_reset();
    pulse_start();
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clock);
      win_ready = (k % 2 == 0);
      if (win_valid === 1'b1) begin
        valid_cnt++;
        if (first_k == 0) first_k = k;
        if (prev_stall) begin
          checks++;
          if ({win_level, win_row, win_col} !== prev_win) begin
            failures++;
            $display("FAIL stall_hold_k%0d: got %h expected %h", k, {win_level, win_row, win_col}, prev_win);
          end
        end
        if (win_ready) begin
          if (n < 6) begin
            checks++;
            if (win_level !== 4'd0 || win_row !== 32'(exp_row[n]) || win_col !== 32'(exp_col[n])) begin
              failures++;
              $display("FAIL stall_window%0d: got (%0d,%0d,%0d) expected (0,%0d,%0d)",
                       n, win_level, win_row, win_col, exp_row[n], exp_col[n]);
            end
          end
          n++;
          last_acc = k;
        end
        prev_stall = ~win_ready;
        prev_win = {win_level, win_row, win_col};
      end else begin
        prev_stall = 1'b0;
      end
      if (done === 1'b1 && done_k == 0) done_k = k;
    end
    win_ready = 1'b0;
    checks++;
    if (n != 6 || valid_cnt != 11) begin
      failures++;
      $display("FAIL stall_counts: got accepts=%0d valid_cycles=%0d expected 6 and 11", n, valid_cnt);
    end
    checks++;
    if (first_k != 6 || last_acc != 16) begin
      failures++;
      $display("FAIL stall_span: got first=%0d last=%0d expected 6 and 16", first_k, last_acc);
    end
    checks++;
    if (done_k != 23) begin failures++; $display("FAIL stall_done: got cycle %0d expected 23", done_k); end
  endtask

  task automatic test_fifo_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      face_in_valid = 1'b1;
      set_det(i);
      @(negedge clock);
      if (i == 0) begin
        checks++;
        if (face_out_valid !== 1'b1 || face_out_row !== 32'd100 || face_out_col !== 32'd200) begin
          failures++;
          $display("FAIL fifo_first_visible: got v=%b row=%0d col=%0d expected v=1 row=100 col=200",
                   face_out_valid, face_out_row, face_out_col);
        end
      end
    end
    set_det(8);
    face_out_ready = 1'b1;
    @(negedge clock);
    face_in_valid = 1'b0;
    face_out_ready = 1'b0;
    checks++;
    if (overflow !== 1'b0 || face_count !== 16'd9) begin
      failures++;
      $display("FAIL fifo_full_pushpop: got ovf=%b cnt=%0d expected ovf=0 cnt=9", overflow, face_count);
    end
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (face_out_valid !== 1'b1 || face_out_level !== 4'(j + 1) ||
          face_out_row !== 32'(101 + j) || face_out_col !== 32'(201 + j)) begin
        failures++;
        $display("FAIL fifo_pushpop_pop%0d: got v=%b lvl=%0d row=%0d col=%0d expected v=1 lvl=%0d row=%0d col=%0d",
                 j, face_out_valid, face_out_level, face_out_row, face_out_col, j + 1, 101 + j, 201 + j);
      end
      face_out_ready = 1'b1;
      @(negedge clock);
    end
    face_out_ready = 1'b0;
    checks++;
    if (face_out_valid !== 1'b0) begin failures++; $display("FAIL fifo_pushpop_empty: got %b expected 0", face_out_valid); end
  endtask

  task automatic test_fifo_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      face_in_valid = 1'b1;
      set_det(i);
      @(negedge clock);
    end
    face_in_valid = 1'b0;
    checks++;
    if (face_count !== 16'd8 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL fifo_overflow: got cnt=%0d ovf=%b expected cnt=8 ovf=1", face_count, overflow);
    end
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (face_out_valid !== 1'b1 || face_out_level !== 4'(j) ||
          face_out_row !== 32'(100 + j) || face_out_col !== 32'(200 + j)) begin
        failures++;
        $display("FAIL fifo_overflow_pop%0d: got v=%b lvl=%0d row=%0d col=%0d expected v=1 lvl=%0d row=%0d col=%0d",
                 j, face_out_valid, face_out_level, face_out_row, face_out_col, j, 100 + j, 200 + j);
      end
      face_out_ready = 1'b1;
      @(negedge clock);
    end
    face_out_ready = 1'b0;
    checks++;
    if (face_out_valid !== 1'b0) begin failures++; $display("FAIL fifo_overflow_empty: got %b expected 0", face_out_valid); end
  endtask

  task automatic test_start_ignored_and_reset();
    int ndone = 0;
    do_reset();
    win_ready = 1'b1;
    pulse_start();
    repeat (6) @(negedge clock);
    start = 1'b1;
    face_in_valid = 1'b1;
    set_det(5);
    @(negedge clock);
    start = 1'b0;
    face_in_valid = 1'b0;
    checks++;
    if (win_valid !== 1'b1 || win_row !== 32'd0 || win_col !== 32'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_ignored: got v=%b row=%0d col=%0d busy=%b expected v=1 row=0 col=2 busy=1",
               win_valid, win_row, win_col, busy);
    end
    checks++;
    if (face_out_valid !== 1'b1) begin failures++; $display("FAIL scan_detect_push: got %b expected 1", face_out_valid); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({win_valid, busy, done, overflow, face_out_valid} !== 5'b0 ||
        {win_level, win_row, win_col} !== 68'h0 ||
        {face_out_level, face_out_row, face_out_col, face_count} !== 84'h0) begin
      failures++;
      $display("FAIL async_reset: got v=%b busy=%b done=%b ovf=%b fov=%b win=%h fifo=%h expected all 0",
               win_valid, busy, done, overflow, face_out_valid, {win_level, win_row, win_col},
               {face_out_level, face_out_row, face_out_col, face_count});
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1 || win_valid === 1'b1) ndone++;
    end
    win_ready = 1'b0;
    checks++;
    if (ndone != 0) begin failures++; $display("FAIL reset_no_done: got %0d active cycles expected 0", ndone); end
  endtask

  task automatic test_restart_keeps_fifo();
    do_reset();
    win_ready = 1'b1;
    pulse_start();
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clock);
      face_in_valid = (k <= 9);
      set_det(k - 1);
    end
    face_in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (face_count !== 16'd8 || overflow !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL restart_before: got cnt=%0d ovf=%b busy=%b expected cnt=8 ovf=1 busy=0", face_count, overflow, busy);
    end
    pulse_start();
    checks++;
    if (face_count !== 16'd0 || overflow !== 1'b0 || busy !== 1'b1 || face_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL restart_clear: got cnt=%0d ovf=%b busy=%b fov=%b expected cnt=0 ovf=0 busy=1 fov=1",
               face_count, overflow, busy, face_out_valid);
    end
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (face_out_valid !== 1'b1 || face_out_row !== 32'(100 + j) || face_out_col !== 32'(200 + j)) begin
        failures++;
        $display("FAIL restart_pop%0d: got v=%b row=%0d col=%0d expected v=1 row=%0d col=%0d",
                 j, face_out_valid, face_out_row, face_out_col, 100 + j, 200 + j);
      end
      face_out_ready = 1'b1;
      @(negedge clock);
    end
    face_out_ready = 1'b0;
    checks++;
    if (face_out_valid !== 1'b0 || face_count !== 16'd0) begin
      failures++;
      $display("FAIL restart_drained: got fov=%b cnt=%0d expected fov=0 cnt=0", face_out_valid, face_count);
    end
    repeat (20) @(negedge clock);
    win_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_full_ready();
    test_scan_stall();
    test_fifo_full_push_pop();
    test_fifo_overflow();
    test_start_ignored_and_reset();
    test_restart_keeps_fifo();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
